// File: rtl/rr_mux_pkg.sv
// Shared constants and types for the 4:1 round-robin output-registered mux.
package rr_mux_pkg;

   localparam int N_CH = 4;
   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

   typedef logic [1:0] ch_idx_t;

   // Channel index 'off' positions after 'base', wrapping modulo N_CH.
   function automatic ch_idx_t idx_add(ch_idx_t base, ch_idx_t off);
      return base + off;
   endfunction

endpackage

// File: rtl/rr_arb_4.sv
// Combinational 4-way round-robin grant search starting at ptr.
module rr_arb_4
   import rr_mux_pkg::*;
(
   input  logic [N_CH-1:0] req,
   input  ch_idx_t         ptr,
   output logic            gnt_vld,
   output ch_idx_t         gnt_idx
);

   // Scan from the farthest candidate back to ptr so the nearest requester wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = ptr;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (req[idx_add(ptr, ch_idx_t'(k))]) begin
            gnt_vld = 1'b1;
            gnt_idx = idx_add(ptr, ch_idx_t'(k));
         end
      end
   end

endmodule

// File: rtl/rr_mux_4_1.sv
// 4:1 round-robin mux with a registered valid/ready output stage.
// Optional feature macro: RR_MUX_GRANT_CNT_EN adds per-channel saturating
// grant counters on port grant_cnt.
//
// Handshake: a channel beat moves when in_valid[i] && in_ready[i]; the output
// beat moves when out_valid && out_ready. The output register may load
// whenever it is empty or being drained this cycle (load).
module rr_mux_4_1
   import rr_mux_pkg::*;
#(
   parameter int W = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [W-1:0]                d0,
   input  logic [W-1:0]                d1,
   input  logic [W-1:0]                d2,
   input  logic [W-1:0]                d3,
   input  logic [N_CH-1:0]             in_valid,
   output logic [N_CH-1:0]             in_ready,
   output logic [W-1:0]                y,
   output logic [1:0]                  sel,
   input  logic                        out_ready,
   output logic                        out_valid
`ifdef RR_MUX_GRANT_CNT_EN
   ,
   output logic [N_CH-1:0][CNT_W-1:0]  grant_cnt
`endif
);

   logic [W-1:0] y_q, y_d;
   ch_idx_t      sel_q, sel_d;
   logic         out_valid_q, out_valid_d;
   ch_idx_t      ptr_q, ptr_d;

   logic         load;
   logic         gnt_vld;
   ch_idx_t      gnt_idx;
   logic [W-1:0] d_sel;

   assign load = !out_valid_q || out_ready;

   rr_arb_4 u_arb (
      .req     (in_valid),
      .ptr     (ptr_q),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx)
   );

   // Route only the granted channel so unknown data elsewhere cannot leak into y.
   always_comb begin
      case (gnt_idx)
         2'd0:    d_sel = d0;
         2'd1:    d_sel = d1;
         2'd2:    d_sel = d2;
         default: d_sel = d3;
      endcase
   end

   // One-hot ready for the granted channel, only when the output can take it.
   always_comb begin
      in_ready = '0;
      if (rst_n && load && gnt_vld) begin
         in_ready[gnt_idx] = 1'b1;
      end
   end

   // Next output-stage state: load a grant, go idle, or hold under backpressure.
   always_comb begin
      y_d         = y_q;
      sel_d       = sel_q;
      out_valid_d = out_valid_q;
      ptr_d       = ptr_q;
      if (load) begin
         if (gnt_vld) begin
            y_d         = d_sel;
            sel_d       = gnt_idx;
            out_valid_d = 1'b1;
            ptr_d       = idx_add(gnt_idx, 2'd1);
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   // Output register and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q         <= '0;
         sel_q       <= '0;
         out_valid_q <= 1'b0;
         ptr_q       <= '0;
      end else begin
         y_q         <= y_d;
         sel_q       <= sel_d;
         out_valid_q <= out_valid_d;
         ptr_q       <= ptr_d;
      end
   end

   assign y         = y_q;
   assign sel       = sel_q;
   assign out_valid = out_valid_q;

`ifdef RR_MUX_GRANT_CNT_EN
   logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;

   // Bump the granted channel's counter, sticking at the maximum.
   always_comb begin
      cnt_d = cnt_q;
      if (load && gnt_vld && (cnt_q[gnt_idx] != CNT_MAX)) begin
         cnt_d[gnt_idx] = cnt_q[gnt_idx] + 8'd1;
      end
   end

   // Grant counters clear only on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rr_mux_4_1.sv
// Bench for rr_mux_4_1: directed vectors, a behavioural reference model
// checked every cycle, and hand-computed literal expectations.
module tb_rr_mux_4_1;
   import rr_mux_pkg::*;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] d0, d1, d2, d3;
   logic [3:0]   in_valid;
   logic [3:0]   in_ready;
   logic [W-1:0] y;
   logic [1:0]   sel;
   logic         out_ready;
   logic         out_valid;
`ifdef RR_MUX_GRANT_CNT_EN
   logic [3:0][7:0] grant_cnt;
`endif

   int errors = 0;
   int checks = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   rr_mux_4_1 #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .d0        (d0),
      .d1        (d1),
      .d2        (d2),
      .d3        (d3),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y         (y),
      .sel       (sel),
      .out_ready (out_ready),
      .out_valid (out_valid)
`ifdef RR_MUX_GRANT_CNT_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int           m_ptr = 0;
   logic         m_valid = 1'b0;
   logic [W-1:0] m_y = '0;
   int           m_sel = 0;
   int           m_cnt[4] = '{0, 0, 0, 0};

   // First requesting channel at or after p, modulo 4; -1 when none.
   function automatic int pick(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++) begin
         if (v[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [W-1:0] chan(input int c);
      case (c)
         0:       return d0;
         1:       return d1;
         2:       return d2;
         default: return d3;
      endcase
   endfunction

   function automatic logic [3:0] exp_ready();
      int g;
      if (!rst_n) return 4'b0000;
      if (m_valid && !out_ready) return 4'b0000;
      g = pick(in_valid, m_ptr);
      if (g < 0) return 4'b0000;
      return 4'b0001 << g;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      int g;
      if (!rst_n) begin
         m_ptr   = 0;
         m_valid = 1'b0;
         m_y     = '0;
         m_sel   = 0;
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else if (!m_valid || out_ready) begin
         g = pick(in_valid, m_ptr);
         if (g >= 0) begin
            m_y     = chan(g);
            m_sel   = g;
            m_valid = 1'b1;
            m_ptr   = (g + 1) % 4;
            if (m_cnt[g] < 255) m_cnt[g]++;
         end else begin
            m_valid = 1'b0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         #2;
         chk("mdl_out_valid", 32'(out_valid), 32'(m_valid));
         chk("mdl_y", 32'(y), 32'(m_y));
         chk("mdl_sel", 32'(sel), 32'(m_sel));
         chk("mdl_in_ready", 32'(in_ready), 32'(exp_ready()));
`ifdef RR_MUX_GRANT_CNT_EN
         for (int i = 0; i < 4; i++) chk("mdl_grant_cnt", 32'(grant_cnt[i]), 32'(m_cnt[i]));
`endif
      end
   end

   // ---------------- driver helpers ----------------
   task automatic set_d(input logic [W-1:0] a, b, c, e);
      d0 = a; d1 = b; d2 = c; d3 = e;
   endtask

   task automatic step();
      @(negedge clk);
      #3;
   endtask

   logic [3:0] tv_valid[8] = '{4'b1010, 4'b0101, 4'b1111, 4'b0001,
                               4'b0000, 4'b1100, 4'b0110, 4'b1111};
   logic       tv_ready[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [W-1:0] rr_exp[4] = '{4'hA, 4'hB, 4'hC, 4'hD};

   // ---------------- directed sequence ----------------
   initial begin
      rst_n     = 1'b0;
      in_valid  = 4'b0000;
      out_ready = 1'b0;
      set_d(4'h0, 4'h0, 4'h0, 4'h0);

      // Reset state.
      repeat (2) step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_y", 32'(y), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);

      // Round robin over all four channels; first grant on the first edge after release.
      rst_n = 1'b1;
      set_d(4'hA, 4'hB, 4'hC, 4'hD);
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rr_sel", 32'(sel), 32'(i % 4));
         chk("rr_y", 32'(y), 32'(rr_exp[i % 4]));
         chk("rr_out_valid", 32'(out_valid), 32'd1);
      end

      // Pointer is now 1; only channel 3 requests, which brings the pointer to 0.
      in_valid = 4'b1000;
      step();
      chk("p3_sel", 32'(sel), 32'd3);
      chk("p3_y", 32'(y), 32'hD);

      // Sparse request with unknown data on the other channels.
      in_valid = 4'b0100;
      set_d('x, 'x, 4'h3, 'x);
      #1;
      chk("sparse_in_ready", 32'(in_ready), 32'b0100);
      step();
      chk("sparse_y", 32'(y), 32'h3);
      chk("sparse_sel", 32'(sel), 32'd2);
      in_valid = 4'b1111;
      set_d(4'h1, 4'h2, 4'h4, 4'h5);
      step();
      chk("sparse_next_sel", 32'(sel), 32'd3);
      chk("sparse_next_y", 32'(y), 32'h5);

      // Backpressure: load 7 from channel 0, then stall three cycles.
      in_valid = 4'b0001;
      set_d(4'h7, 4'h2, 4'h4, 4'h5);
      step();
      chk("bp_load_y", 32'(y), 32'h7);
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      set_d(4'h1, 4'h2, 4'h4, 4'h5);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_in_ready", 32'(in_ready), 32'b0000);
         step();
         chk("bp_y_hold", 32'(y), 32'h7);
         chk("bp_valid_hold", 32'(out_valid), 32'd1);
         chk("bp_sel_hold", 32'(sel), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 32'b0010);
      step();
      chk("bp_release_y", 32'(y), 32'h2);
      chk("bp_release_sel", 32'(sel), 32'd1);

      // Idle: nothing requested, output empties and y holds.
      in_valid = 4'b0000;
      step();
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_y", 32'(y), 32'h2);
      chk("idle_sel", 32'(sel), 32'd1);

      // Mixed request / ready table, checked by the model.
      set_d(4'h9, 4'h6, 4'hE, 4'h3);
      for (int i = 0; i < 8; i++) begin
         in_valid  = tv_valid[i];
         out_ready = tv_ready[i];
         step();
      end

      // Reset in the middle of a stream.
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      set_d(4'h1, 4'h2, 4'h4, 4'h5);
      step();
      chk("mid_pre_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_y", 32'(y), 32'd0);
      chk("mid_rst_sel", 32'(sel), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("mid_first_sel", 32'(sel), 32'd0);
      chk("mid_first_y", 32'(y), 32'h1);
      chk("mid_first_valid", 32'(out_valid), 32'd1);

      // Sustained grants to channel 1 (saturates its counter when enabled).
      in_valid = 4'b0010;
      repeat (300) step();
      chk("ch1_sel", 32'(sel), 32'd1);
      chk("ch1_y", 32'(y), 32'h2);
`ifdef RR_MUX_GRANT_CNT_EN
      chk("cnt1_sat", 32'(grant_cnt[1]), 32'd255);
      chk("cnt0", 32'(grant_cnt[0]), 32'd1);
      chk("cnt2", 32'(grant_cnt[2]), 32'd0);
      chk("cnt3", 32'(grant_cnt[3]), 32'd0);
`endif

      in_valid = 4'b0000;
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
